// File: rtl/stack_rpn_seq_if.sv
// stack_rpn_seq_if: command/response handshake plus stack strobe bus of the RPN sequencer.
interface stack_rpn_seq_if #(parameter int WIDTH = 8, parameter int DEPTH = 256);
  localparam int IW = $clog2(DEPTH);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [WIDTH-1:0] cmd_data;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic [1:0]       rsp_err;
  logic             st_push_en;
  logic             st_pop_en;
  logic             st_peek_en;
  logic             st_poke_en;
  logic [WIDTH-1:0] st_data_in;
  logic [IW-1:0]    st_index;
  logic [WIDTH-1:0] st_data_out;
  logic             st_full;
  logic [IW:0]      st_depth;
  modport slave (
    input  cmd_valid, cmd_op, cmd_data, rsp_ready, st_data_out, st_full, st_depth,
    output cmd_ready, rsp_valid, rsp_data, rsp_err,
           st_push_en, st_pop_en, st_peek_en, st_poke_en, st_data_in, st_index
  );
  modport master (
    output cmd_valid, cmd_op, cmd_data, rsp_ready, st_data_out, st_full, st_depth,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err,
           st_push_en, st_pop_en, st_peek_en, st_poke_en, st_data_in, st_index
  );
endinterface

// File: rtl/stack_rpn_seq.sv
// stack_rpn_seq: expands one RPN opcode per handshake into a fixed sequence of stack
// push/pop/peek/poke strobes and returns one response with result and error code.
module stack_rpn_seq #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  stack_rpn_seq_if.slave    bus
);
  localparam int IW = $clog2(DEPTH);
  typedef enum logic [2:0] {IDLE, X1, X2, X3, X4, RSP} state_t;
  typedef enum logic [2:0] {OP_PUSH, OP_POP, OP_DUP, OP_DROP, OP_SWAP, OP_ADD, OP_SUB, OP_XOR} op_t;
  state_t           state_q, state_d;
  op_t              op_q, op_d;
  logic [WIDTH-1:0] data_q, data_d, a_q, a_d, b_q, b_d, rsp_data_q, rsp_data_d, alu_r;
  logic [1:0]       rsp_err_q, rsp_err_d;
  logic             push, pop, peek, poke, under, over, is_swap;
  logic [WIDTH-1:0] din;
  logic [IW-1:0]    idx;
  logic [IW:0]      need;
  op_t              in_op;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      op_q       <= OP_PUSH;
      data_q     <= '0;
      a_q        <= '0;
      b_q        <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      data_q     <= data_d;
      a_q        <= a_d;
      b_q        <= b_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end
  always_comb begin
    in_op   = op_t'(bus.cmd_op);
    need    = (in_op == OP_PUSH) ? (IW+1)'(0) : (in_op >= OP_SWAP) ? (IW+1)'(2) : (IW+1)'(1);
    under   = bus.st_depth < need;
    over    = (in_op == OP_PUSH || in_op == OP_DUP) && bus.st_full;
    is_swap = op_q == OP_SWAP;
    // B is the second element, A the top: R = B op A
    alu_r   = (op_q == OP_ADD) ? b_q + a_q : (op_q == OP_SUB) ? b_q - a_q : b_q ^ a_q;
  end
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    data_d     = data_q;
    a_d        = a_q;
    b_d        = b_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    push       = 1'b0;
    pop        = 1'b0;
    peek       = 1'b0;
    poke       = 1'b0;
    din        = '0;
    idx        = '0;
    case (state_q)
      IDLE: if (bus.cmd_valid) begin
        op_d       = in_op;
        data_d     = bus.cmd_data;
        rsp_data_d = '0;
        rsp_err_d  = under ? 2'b01 : over ? 2'b10 : 2'b00;
        state_d    = (under || over) ? RSP : X1;
      end
      X1: begin
        peek       = op_q != OP_PUSH && op_q != OP_DROP;
        push       = op_q == OP_PUSH;
        pop        = op_q == OP_POP || op_q == OP_DROP;
        din        = push ? data_q : '0;
        a_d        = bus.st_data_out;
        rsp_data_d = push ? data_q : (op_q == OP_POP) ? bus.st_data_out : '0;
        state_d    = (op_q == OP_PUSH || op_q == OP_POP || op_q == OP_DROP) ? RSP : X2;
      end
      X2: begin
        push       = op_q == OP_DUP;
        peek       = !push;
        din        = push ? a_q : '0;
        idx        = push ? IW'(0) : IW'(1);
        b_d        = bus.st_data_out;
        rsp_data_d = a_q;
        state_d    = push ? RSP : X3;
      end
      X3: begin
        // ALU writes R under the top and pops it in the same cycle
        poke       = 1'b1;
        pop        = !is_swap;
        idx        = is_swap ? IW'(0) : IW'(1);
        din        = is_swap ? b_q : alu_r;
        rsp_data_d = is_swap ? b_q : alu_r;
        state_d    = is_swap ? X4 : RSP;
      end
      X4: begin
        poke    = 1'b1;
        idx     = IW'(1);
        din     = a_q;
        state_d = RSP;
      end
      RSP:     state_d = bus.rsp_ready ? IDLE : RSP;
      default: state_d = IDLE;
    endcase
  end
  assign bus.cmd_ready  = state_q == IDLE;
  assign bus.rsp_valid  = state_q == RSP;
  assign bus.rsp_data   = rsp_data_q;
  assign bus.rsp_err    = rsp_err_q;
  assign bus.st_push_en = push;
  assign bus.st_pop_en  = pop;
  assign bus.st_peek_en = peek;
  assign bus.st_poke_en = poke;
  assign bus.st_data_in = din;
  assign bus.st_index   = idx;
endmodule

// File: tb/tb_stack_rpn_seq.sv
// tb_stack_rpn_seq: directed tests of the RPN sequencer against a small 4-deep stack model.
module tb_stack_rpn_seq;
  localparam logic [2:0] PUSH = 3'd0, POP = 3'd1, DUP = 3'd2, DROP = 3'd3,
                         SWAP = 3'd4, ADD = 3'd5, SUB = 3'd6, XOR = 3'd7;
  logic clk = 1'b0;
  logic rst_n;
  logic st_clr;
  int   n_chk = 0;
  int   n_fail = 0;
  int   strobe_cnt = 0;
  logic [7:0] mem [0:3];
  logic [2:0] depth;
  always #5 clk = ~clk;
  stack_rpn_seq_if #(.WIDTH(8), .DEPTH(4)) bus ();
  stack_rpn_seq #(.WIDTH(8), .DEPTH(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  // stack model: mem[depth-1] is the top (index 0); poke addresses before a same-cycle pop
  assign bus.st_depth    = depth;
  assign bus.st_full     = depth == 3'd4;
  assign bus.st_data_out = (bus.st_peek_en && {1'b0, bus.st_index} < depth) ?
                           mem[2'(depth - 3'd1 - {1'b0, bus.st_index})] : 8'h00;
  always @(posedge clk) begin
    if (bus.st_push_en || bus.st_pop_en || bus.st_peek_en || bus.st_poke_en) strobe_cnt <= strobe_cnt + 1;
    if (st_clr) depth <= 3'd0;
    else begin
      if (bus.st_push_en && depth < 3'd4) begin
        mem[depth[1:0]] <= bus.st_data_in;
        depth <= depth + 3'd1;
      end
      if (bus.st_poke_en) mem[2'(depth - 3'd1 - {1'b0, bus.st_index})] <= bus.st_data_in;
      if (bus.st_pop_en && depth > 3'd0) depth <= depth - 3'd1;
    end
  end
  task automatic do_cmd(input logic [2:0] op, input logic [7:0] d,
                        output logic [7:0] rd, output logic [1:0] re, output int lat);
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_data  = d;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_data  = 8'h00;
    lat = 1;
    while (!bus.rsp_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!bus.rsp_valid) begin
      n_chk++; n_fail++;
      $display("FAIL rsp_timeout op=%0d rsp_valid=0 required 1", op);
    end
    rd = bus.rsp_data;
    re = bus.rsp_err;
    @(negedge clk);
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
  endtask
  task automatic clear_stack();
    @(negedge clk);
    st_clr = 1'b1;
    @(negedge clk);
    st_clr = 1'b0;
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    st_clr = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op = 3'd0;
    bus.cmd_data = 8'h00;
    bus.rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    n_chk++;
    if (bus.cmd_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_hs cmd_ready=%b rsp_valid=%b required 1 0", bus.cmd_ready, bus.rsp_valid);
    end
    n_chk++;
    if (bus.rsp_data !== 8'h00 || bus.rsp_err !== 2'b00) begin
      n_fail++; $display("FAIL reset_rsp data=%h err=%b required 00 00", bus.rsp_data, bus.rsp_err);
    end
    n_chk++;
    if ({bus.st_push_en, bus.st_pop_en, bus.st_peek_en, bus.st_poke_en} !== 4'b0 ||
        bus.st_index !== 2'd0 || bus.st_data_in !== 8'h00) begin
      n_fail++; $display("FAIL reset_strobes strobes=%b idx=%0d din=%h required 0", {bus.st_push_en,
        bus.st_pop_en, bus.st_peek_en, bus.st_poke_en}, bus.st_index, bus.st_data_in);
    end
    rst_n = 1'b1;
    st_clr = 1'b0;
  endtask
  task automatic test_sub();
    logic [7:0] rd; logic [1:0] re; int lat;
    do_cmd(PUSH, 8'd5, rd, re, lat);
    n_chk++;
    if (rd !== 8'd5 || re !== 2'b00 || lat != 2) begin
      n_fail++; $display("FAIL push5 data=%0d err=%b lat=%0d required 5 00 2", rd, re, lat);
    end
    do_cmd(PUSH, 8'd3, rd, re, lat);
    do_cmd(SUB, 8'd0, rd, re, lat);
    n_chk++;
    if (rd !== 8'd2 || re !== 2'b00 || lat != 4 || depth !== 3'd1) begin
      n_fail++; $display("FAIL sub data=%0d err=%b lat=%0d depth=%0d required 2 00 4 1", rd, re, lat, depth);
    end
    do_cmd(POP, 8'd0, rd, re, lat);
    n_chk++;
    if (rd !== 8'd2 || lat != 2 || depth !== 3'd0) begin
      n_fail++; $display("FAIL pop_sub data=%0d lat=%0d depth=%0d required 2 2 0", rd, lat, depth);
    end
  endtask
  task automatic test_add_xor();
    logic [7:0] rd; logic [1:0] re; int lat;
    do_cmd(PUSH, 8'd200, rd, re, lat);
    do_cmd(PUSH, 8'd100, rd, re, lat);
    do_cmd(ADD, 8'd0, rd, re, lat);
    n_chk++;
    if (rd !== 8'd44 || re !== 2'b00 || depth !== 3'd1) begin
      n_fail++; $display("FAIL add_wrap data=%0d err=%b depth=%0d required 44 00 1", rd, re, depth);
    end
    do_cmd(POP, 8'd0, rd, re, lat);
    n_chk++;
    if (rd !== 8'd44) begin
      n_fail++; $display("FAIL pop_add data=%0d required 44", rd);
    end
    do_cmd(PUSH, 8'hF0, rd, re, lat);
    do_cmd(PUSH, 8'h0F, rd, re, lat);
    do_cmd(XOR, 8'd0, rd, re, lat);
    n_chk++;
    if (rd !== 8'hFF || mem[0] !== 8'hFF || depth !== 3'd1) begin
      n_fail++; $display("FAIL xor data=%h stack=%h depth=%0d required ff ff 1", rd, mem[0], depth);
    end
    do_cmd(DROP, 8'd0, rd, re, lat);
    n_chk++;
    if (rd !== 8'h00 || re !== 2'b00 || lat != 2 || depth !== 3'd0) begin
      n_fail++; $display("FAIL drop data=%h err=%b lat=%0d depth=%0d required 00 00 2 0", rd, re, lat, depth);
    end
  endtask
  task automatic test_swap_dup();
    logic [7:0] rd; logic [1:0] re; int lat;
    do_cmd(PUSH, 8'd1, rd, re, lat);
    do_cmd(PUSH, 8'd2, rd, re, lat);
    do_cmd(SWAP, 8'd0, rd, re, lat);
    n_chk++;
    if (rd !== 8'd1 || re !== 2'b00 || lat != 5 || depth !== 3'd2) begin
      n_fail++; $display("FAIL swap data=%0d err=%b lat=%0d depth=%0d required 1 00 5 2", rd, re, lat, depth);
    end
    do_cmd(POP, 8'd0, rd, re, lat);
    n_chk++;
    if (rd !== 8'd1) begin n_fail++; $display("FAIL swap_pop1 data=%0d required 1", rd); end
    do_cmd(POP, 8'd0, rd, re, lat);
    n_chk++;
    if (rd !== 8'd2) begin n_fail++; $display("FAIL swap_pop2 data=%0d required 2", rd); end
    do_cmd(PUSH, 8'd7, rd, re, lat);
    do_cmd(DUP, 8'd0, rd, re, lat);
    n_chk++;
    if (rd !== 8'd7 || lat != 3 || depth !== 3'd2 || mem[0] !== 8'd7 || mem[1] !== 8'd7) begin
      n_fail++; $display("FAIL dup data=%0d lat=%0d depth=%0d stack=%0d,%0d required 7 3 2 7,7",
        rd, lat, depth, mem[0], mem[1]);
    end
    clear_stack();
  endtask
  task automatic test_underflow();
    logic [7:0] rd; logic [1:0] re; int lat, s0;
    s0 = strobe_cnt;
    do_cmd(POP, 8'd0, rd, re, lat);
    n_chk++;
    if (rd !== 8'h00 || re !== 2'b01 || lat != 1) begin
      n_fail++; $display("FAIL uf_pop data=%h err=%b lat=%0d required 00 01 1", rd, re, lat);
    end
    do_cmd(DROP, 8'd0, rd, re, lat);
    n_chk++;
    if (rd !== 8'h00 || re !== 2'b01) begin
      n_fail++; $display("FAIL uf_drop data=%h err=%b required 00 01", rd, re);
    end
    do_cmd(DUP, 8'd0, rd, re, lat);
    n_chk++;
    if (rd !== 8'h00 || re !== 2'b01) begin
      n_fail++; $display("FAIL uf_dup data=%h err=%b required 00 01", rd, re);
    end
    n_chk++;
    if (strobe_cnt != s0 || depth !== 3'd0) begin
      n_fail++; $display("FAIL uf_no_strobes strobes=%0d depth=%0d required 0 0", strobe_cnt - s0, depth);
    end
    do_cmd(PUSH, 8'd4, rd, re, lat);
    do_cmd(ADD, 8'd0, rd, re, lat);
    n_chk++;
    if (rd !== 8'h00 || re !== 2'b01 || depth !== 3'd1) begin
      n_fail++; $display("FAIL uf_add data=%h err=%b depth=%0d required 00 01 1", rd, re, depth);
    end
    clear_stack();
  endtask
  task automatic test_overflow();
    logic [7:0] rd; logic [1:0] re; int lat;
    for (int i = 0; i < 4; i++) do_cmd(PUSH, 8'(10 + i), rd, re, lat);
    do_cmd(PUSH, 8'd9, rd, re, lat);
    n_chk++;
    if (rd !== 8'h00 || re !== 2'b10 || lat != 1 || depth !== 3'd4) begin
      n_fail++; $display("FAIL of_push data=%h err=%b lat=%0d depth=%0d required 00 10 1 4", rd, re, lat, depth);
    end
    do_cmd(DUP, 8'd0, rd, re, lat);
    n_chk++;
    if (re !== 2'b10 || depth !== 3'd4) begin
      n_fail++; $display("FAIL of_dup err=%b depth=%0d required 10 4", re, depth);
    end
    do_cmd(POP, 8'd0, rd, re, lat);
    n_chk++;
    if (rd !== 8'd13 || re !== 2'b00) begin
      n_fail++; $display("FAIL of_top data=%0d err=%b required 13 00", rd, re);
    end
    clear_stack();
  endtask
  task automatic test_hold();
    int lat, bad;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op = PUSH;
    bus.cmd_data = 8'h5A;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    lat = 1;
    while (!bus.rsp_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 8'h5A || bus.rsp_err !== 2'b00 || bus.cmd_ready !== 1'b0) bad++;
    end
    n_chk++;
    if (bad != 0) begin
      n_fail++; $display("FAIL rsp_hold unstable_cycles=%0d data=%h cmd_ready=%b required 0 5a 0",
        bad, bus.rsp_data, bus.cmd_ready);
    end
    @(negedge clk);
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
    n_chk++;
    if (bus.cmd_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL rsp_release cmd_ready=%b rsp_valid=%b required 1 0", bus.cmd_ready, bus.rsp_valid);
    end
    clear_stack();
  endtask
  task automatic test_reset_mid_swap();
    logic [7:0] rd; logic [1:0] re; int lat;
    do_cmd(PUSH, 8'd1, rd, re, lat);
    do_cmd(PUSH, 8'd2, rd, re, lat);
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op = SWAP;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    @(posedge clk);
    #1;
    n_chk++;
    if (bus.st_peek_en !== 1'b1 || bus.st_index !== 2'd1) begin
      n_fail++; $display("FAIL swap_x2 peek=%b idx=%0d required 1 1", bus.st_peek_en, bus.st_index);
    end
    rst_n = 1'b0;
    #1;
    n_chk++;
    if ({bus.st_push_en, bus.st_pop_en, bus.st_peek_en, bus.st_poke_en} !== 4'b0 ||
        bus.cmd_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL async_abort strobes=%b cmd_ready=%b rsp_valid=%b required 0000 1 0",
        {bus.st_push_en, bus.st_pop_en, bus.st_peek_en, bus.st_poke_en}, bus.cmd_ready, bus.rsp_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    do_cmd(POP, 8'd0, rd, re, lat);
    n_chk++;
    if (rd !== 8'd2 || re !== 2'b00 || depth !== 3'd1) begin
      n_fail++; $display("FAIL post_abort data=%0d err=%b depth=%0d required 2 00 1", rd, re, depth);
    end
  endtask
  initial begin
    test_reset();
    test_sub();
    test_add_xor();
    test_swap_dup();
    test_underflow();
    test_overflow();
    test_hold();
    test_reset_mid_swap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
